eda_local_max_stream: RTL and testbench
=======================================

Name: eda_local_max_stream

Overview:
- Streaming successor to the RAM-based regional-max engine. Accepts an M x N image in raster order over a valid/ready handshake.
- Produces a per-pixel local-maximum candidate flag, also in raster order, with coordinates.
- Supports 4- or 8-connectivity and strict or non-strict compare, selectable per frame.
- Feeds the iterative plateau-resolution stage, so that stage no longer needs a full image RAM load before starting.

Parameters:
- M, 16, image rows.
- N, 16, image columns.
- PIXEL_WIDTH, 8, pixel bit width (unsigned).
- I_WIDTH, 4, row index width; must satisfy 2**I_WIDTH >= M.
- J_WIDTH, 4, column index width; must satisfy 2**J_WIDTH >= N.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle pulse that begins a frame; ignored while busy=1.
- conn8  in  1  1 = 8-connectivity, 0 = 4-connectivity; sampled on accepted start.
- strict  in  1  1 = centre > neighbours, 0 = centre >= neighbours; sampled on accepted start.
- pixel_in  in  PIXEL_WIDTH  input pixel, raster order.
- pixel_valid  in  1  pixel_in is valid.
- pixel_ready  out  1  block accepts pixel_in this cycle.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_flag  out  1  1 = local-max candidate.
- out_i  out  I_WIDTH  row of the flagged pixel.
- out_j  out  J_WIDTH  column of the flagged pixel.
- out_last  out  1  set on the beat for pixel (M-1, N-1).
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the final output handshake.

Behaviour:
- Reset: all outputs are 0 (pixel_ready, out_valid, out_flag, out_i, out_j, out_last, busy, done). Line buffers and window are cleared to pad. FSM goes to IDLE. Reset mid-frame abandons the frame; no done is issued.
- FSM states:
  - IDLE: on start, latch conn8/strict, zero the virtual counters (vr, vc) and go to RUN; busy=1 from the next cycle.
  - RUN: scans a virtual raster vr=0..M, vc=0..N, i.e. (M+1)*(N+1) steps with step k = vr*(N+1)+vc. At the end of step (M, N) go to DRAIN.
  - DRAIN: wait for the last out handshake, then go to IDLE with done=1 for one cycle and busy=0.
- Virtual positions with vr<M and vc<N are real and consume one pixel. All other positions inject a pad element and consume nothing.
- pixel_ready = (state==RUN) && real position && step_enable_without_input.
- A step fires when:
  - (real ? pixel_valid : 1), and
  - the output register is empty or is being accepted this cycle (out_ready && out_valid).
- Storage:
  - Window elements are {pad, value}. Pad compares less than any real value in both modes.
  - Two line buffers, each depth N+1, plus a 3x3 register window. All shift only on step fire.
- Output generation: on a step at (vr, vc) with vr>=1 and vc>=1, the window centre is pixel (vr-1, vc-1).
  - The output register loads flag, out_i=vr-1, out_j=vc-1, and out_last=(vr==M && vc==N).
  - out_valid rises the next cycle.
- Flag rule: the centre is compared against the non-pad neighbours (N/S/E/W, plus the diagonals when conn8). Use > for strict, >= for non-strict. An all-pad neighbourhood cannot occur for M,N >= 2.
- Latency: the beat for (0,0) goes valid the cycle after step N+2, i.e. after N+2 accepted pixels under no stall.
- Throughput: 1 step per cycle when unstalled.
- Backpressure:
  - While out_valid && !out_ready, no step fires.
  - pixel_ready=0 and all out_* are held stable.
  - No beat is lost or duplicated.
- pixel_valid held low stalls only real steps; pad steps proceed.
- Counters: vc wraps N -> 0 and increments vr. The comparisons are full-width, so there is no overflow for M,N < 2**width.

Decomposition:
- Package eda_local_max_pkg holds:
  - the state_t enum (IDLE, RUN, DRAIN);
  - the win_elem_t struct {logic pad; logic [PIXEL_WIDTH-1:0] val};
  - the function gt_pad(a, b, strict).
- Defaults are taken from the global CFG_* defines.
- One sub-module, eda_line_buffer: a parametrised depth/width shift delay line with enable, instantiated twice.

Test Plan:
- M=N=4, all pixels 5, strict=0 -> 16 beats, all out_flag=1, out_last only at (3,3), then done pulse. With strict=1 -> all out_flag=0.
- M=N=4, zeros except (1,1)=5 and (2,2)=7, strict=1:
  - conn8=0 -> flags at (1,1) and (2,2) only;
  - conn8=1 -> flag at (2,2) only.
- M=N=4, (0,0)=255, rest 0, strict=0 -> flags=1 everywhere except (0,1), (1,0), (1,1); confirms pad handling at the border.
- Hold out_ready=0 for 10 cycles mid-frame -> out_* stable, pixel_ready=0, the full 16-beat sequence is intact and in order afterwards.
- Random pixel_valid gaps (50%) and random out_ready -> the flag map matches a golden model over 20 random 4x4 and 16x16 frames. start pulses while busy are ignored.
- reset_n low after 7 pixels -> outputs go 0 immediately, no done. A new start then processes a full frame correctly.

Source files
------------

// File: rtl/eda_local_max_pkg.sv
// Shared types and helpers for the streaming local-maximum engine.
`ifndef CFG_M
`define CFG_M 16
`endif
`ifndef CFG_N
`define CFG_N 16
`endif
`ifndef CFG_PIXEL_WIDTH
`define CFG_PIXEL_WIDTH 8
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 4
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 4
`endif

package eda_local_max_pkg;

  localparam int PKG_M           = `CFG_M;
  localparam int PKG_N           = `CFG_N;
  localparam int PKG_PIXEL_WIDTH = `CFG_PIXEL_WIDTH;
  localparam int PKG_I_WIDTH     = `CFG_I_WIDTH;
  localparam int PKG_J_WIDTH     = `CFG_J_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // A window element: pad marks a position outside the image.
  typedef struct packed {
    logic                       pad;
    logic [PKG_PIXEL_WIDTH-1:0] val;
  } win_elem_t;

  // True when centre a dominates neighbour b. Pad is below every real value.
  function automatic logic gt_pad(input win_elem_t a, input win_elem_t b,
                                  input logic strict);
    logic r;
    if (b.pad)       r = !a.pad;
    else if (a.pad)  r = 1'b0;
    else if (strict) r = (a.val > b.val);
    else             r = (a.val >= b.val);
    return r;
  endfunction

endpackage

// File: rtl/eda_line_buffer.sv
// Fixed-depth shift delay line: dout is din from DEPTH enabled steps ago.
module eda_line_buffer #(
  parameter int               DEPTH     = 17,
  parameter int               WIDTH     = 9,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Shift one place towards the tail when enabled.
  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
    end
  end

  // Storage; reset fills the line with the reset element.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/eda_local_max_stream.sv
// Streaming 3x3 local-maximum candidate flagger over a padded virtual raster.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// pixel_valid may not depend on pixel_ready; out_* hold stable while
// out_valid && !out_ready.
//
// The scan walks vr=0..M, vc=0..N. The extra row/column inject pad so the
// window centre (vr-1, vc-1) always has its south/east neighbours available
// and the border naturally sees pad on the other sides.
module eda_local_max_stream
  import eda_local_max_pkg::*;
#(
  parameter int M           = PKG_M,
  parameter int N           = PKG_N,
  parameter int PIXEL_WIDTH = PKG_PIXEL_WIDTH,  // must equal PKG_PIXEL_WIDTH
  parameter int I_WIDTH     = PKG_I_WIDTH,
  parameter int J_WIDTH     = PKG_J_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   conn8,
  input  logic                   strict,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   pixel_valid,
  output logic                   pixel_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_flag,
  output logic [I_WIDTH-1:0]     out_i,
  output logic [J_WIDTH-1:0]     out_j,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output state_t                 dbg_state
);

  localparam int VR_W = I_WIDTH + 1;
  localparam int VC_W = J_WIDTH + 1;
  localparam int EW   = PKG_PIXEL_WIDTH + 1;
  localparam logic [VR_W-1:0] LAST_VR = VR_W'(M);
  localparam logic [VC_W-1:0] LAST_VC = VC_W'(N);
  localparam win_elem_t PAD_ELEM = '{pad: 1'b1, val: '0};

  state_t            state_q, state_d;
  logic [VR_W-1:0]   vr_q, vr_d;
  logic [VC_W-1:0]   vc_q, vc_d;
  logic              conn8_q, conn8_d;
  logic              strict_q, strict_d;
  win_elem_t         win_q [3][3];
  win_elem_t         win_d [3][3];
  logic              out_valid_q, out_valid_d;
  logic              out_flag_q, out_flag_d;
  logic [I_WIDTH-1:0] out_i_q, out_i_d;
  logic [J_WIDTH-1:0] out_j_q, out_j_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              real_pos, out_free, step_fire, emit, flag_c;
  win_elem_t         x_elem, lb0_out, lb1_out, ctr;
  logic [EW-1:0]     lb0_raw, lb1_raw;

  assign real_pos    = (vr_q < LAST_VR) && (vc_q < LAST_VC);
  assign out_free    = !out_valid_q || out_ready;
  assign step_fire   = (state_q == RUN) && (real_pos ? pixel_valid : 1'b1) && out_free;
  assign pixel_ready = (state_q == RUN) && real_pos && out_free;
  assign emit        = step_fire && (vr_q != '0) && (vc_q != '0);

  // Element entering the window this step: the pixel or pad.
  always_comb begin
    x_elem.pad = !real_pos;
    x_elem.val = real_pos ? pixel_in : '0;
  end

  // lb0 yields the row above the incoming element, lb1 two rows above.
  eda_line_buffer #(.DEPTH(N + 1), .WIDTH(EW), .RESET_VAL(PAD_ELEM)) u_lb0 (
    .clk(clk), .reset_n(reset_n), .en(step_fire), .din(x_elem), .dout(lb0_raw)
  );
  eda_line_buffer #(.DEPTH(N + 1), .WIDTH(EW), .RESET_VAL(PAD_ELEM)) u_lb1 (
    .clk(clk), .reset_n(reset_n), .en(step_fire), .din(lb0_raw), .dout(lb1_raw)
  );

  assign lb0_out = lb0_raw;
  assign lb1_out = lb1_raw;

  // Flag for the post-shift centre, read from the pre-shift window plus new column.
  always_comb begin
    ctr    = win_q[1][2];
    flag_c = gt_pad(ctr, win_q[0][2], strict_q) & gt_pad(ctr, win_q[2][2], strict_q)
           & gt_pad(ctr, win_q[1][1], strict_q) & gt_pad(ctr, lb0_out, strict_q);
    if (conn8_q) begin
      flag_c = flag_c & gt_pad(ctr, win_q[0][1], strict_q) & gt_pad(ctr, win_q[2][1], strict_q)
             & gt_pad(ctr, lb1_out, strict_q) & gt_pad(ctr, x_elem, strict_q);
    end
  end

  // Next-state, counters, window shift and output register.
  always_comb begin
    state_d     = state_q;
    vr_d        = vr_q;
    vc_d        = vc_q;
    conn8_d     = conn8_q;
    strict_d    = strict_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_flag_d  = out_flag_q;
    out_i_d     = out_i_q;
    out_j_d     = out_j_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          vr_d     = '0;
          vc_d     = '0;
          conn8_d  = conn8;
          strict_d = strict;
        end
      end
      RUN: begin
        if (step_fire) begin
          for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
          end
          win_d[0][2] = lb1_out;
          win_d[1][2] = lb0_out;
          win_d[2][2] = x_elem;
          if (emit) begin
            out_valid_d = 1'b1;
            out_flag_d  = flag_c;
            out_i_d     = I_WIDTH'(vr_q - VR_W'(1));
            out_j_d     = J_WIDTH'(vc_q - VC_W'(1));
            out_last_d  = (vr_q == LAST_VR) && (vc_q == LAST_VC);
          end
          if (vc_q == LAST_VC) begin
            vc_d = '0;
            vr_d = vr_q + VR_W'(1);
          end else begin
            vc_d = vc_q + VC_W'(1);
          end
          if ((vr_q == LAST_VR) && (vc_q == LAST_VC)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      vr_q        <= '0;
      vc_q        <= '0;
      conn8_q     <= 1'b0;
      strict_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_flag_q  <= 1'b0;
      out_i_q     <= '0;
      out_j_q     <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= PAD_ELEM;
    end else begin
      state_q     <= state_d;
      vr_q        <= vr_d;
      vc_q        <= vc_d;
      conn8_q     <= conn8_d;
      strict_q    <= strict_d;
      out_valid_q <= out_valid_d;
      out_flag_q  <= out_flag_d;
      out_i_q     <= out_i_d;
      out_j_q     <= out_j_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      win_q       <= win_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flag  = out_flag_q;
  assign out_i     = out_i_q;
  assign out_j     = out_j_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_eda_local_max_stream.sv
// Bench for eda_local_max_stream: a 4x4 and a 16x16 instance, one active at a time.
module tb_eda_local_max_stream;
  import eda_local_max_pkg::*;

  localparam int W = 10;  // {flag, i[3:0], j[3:0], last}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] start_v = '0, valid_v = '0, ready_v = '0;
  logic       conn8_in = 1'b0, strict_in = 1'b0;
  logic [7:0] pix_in = '0;
  logic       p_ready [2], o_valid [2], o_flag [2], o_last [2], o_busy [2], o_done [2];
  logic [3:0] o_i [2], o_j [2];
  state_t     dbg [2];

  eda_local_max_stream #(.M(4), .N(4), .PIXEL_WIDTH(8), .I_WIDTH(4), .J_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .conn8(conn8_in), .strict(strict_in),
    .pixel_in(pix_in), .pixel_valid(valid_v[0]), .pixel_ready(p_ready[0]),
    .out_valid(o_valid[0]), .out_ready(ready_v[0]), .out_flag(o_flag[0]),
    .out_i(o_i[0]), .out_j(o_j[0]), .out_last(o_last[0]), .busy(o_busy[0]),
    .done(o_done[0]), .dbg_state(dbg[0])
  );

  eda_local_max_stream #(.M(16), .N(16), .PIXEL_WIDTH(8), .I_WIDTH(4), .J_WIDTH(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .conn8(conn8_in), .strict(strict_in),
    .pixel_in(pix_in), .pixel_valid(valid_v[1]), .pixel_ready(p_ready[1]),
    .out_valid(o_valid[1]), .out_ready(ready_v[1]), .out_flag(o_flag[1]),
    .out_i(o_i[1]), .out_j(o_j[1]), .out_last(o_last[1]), .busy(o_busy[1]),
    .done(o_done[1]), .dbg_state(dbg[1])
  );

  // ---------------- shared state ----------------
  int total = 0;
  int bad = 0;
  int sel = 0;
  int rdy_pct = 100;
  bit hold_go = 1'b0;
  int done_cnt = 0, beat_cnt = 0, flag_cnt = 0, last_cnt = 0;
  logic [W-1:0] exp_q [$];
  int img [16][16];
  logic stall_prev = 1'b0;
  logic [W-1:0] prev_beat = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A pixel is a candidate if it beats every in-image neighbour of the chosen shape.
  function automatic bit ref_flag(int i, int j, int m, int n, bit c8, bit st);
    bit f = 1'b1;
    for (int di = -1; di <= 1; di++) begin
      for (int dj = -1; dj <= 1; dj++) begin
        int ii = i + di;
        int jj = j + dj;
        if (di == 0 && dj == 0) continue;
        if (!c8 && di != 0 && dj != 0) continue;
        if (ii < 0 || jj < 0 || ii >= m || jj >= n) continue;
        if (st ? !(img[i][j] > img[ii][jj]) : !(img[i][j] >= img[ii][jj])) f = 1'b0;
      end
    end
    return f;
  endfunction

  task automatic fill_img(input int maxv);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) img[i][j] = $urandom_range(0, maxv);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) img[i][j] = v;
  endtask

  function automatic logic [W-1:0] cur_beat();
    return {o_flag[sel], o_i[sel], o_j[sel], o_last[sel]};
  endfunction

  // ---------------- out_ready driver (random, with optional 10-cycle hold) ----------------
  initial begin
    forever begin
      @(posedge clk); #2;
      if (hold_go) begin
        hold_go = 1'b0;
        for (int c = 0; c < 10; c++) begin
          ready_v = '0;
          @(negedge clk);
          if (c >= 2) begin
            chk("hold_out_valid", o_valid[sel], 1);
            chk("hold_pixel_ready", p_ready[sel], 0);
          end
          @(posedge clk); #2;
        end
      end
      ready_v = '0;
      ready_v[sel] = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (stall_prev) begin
        chk("stall_valid_held", o_valid[sel], 1);
        chk("stall_beat_held", cur_beat(), prev_beat);
      end
      if (o_valid[sel] && !ready_v[sel]) chk("stall_pixel_ready", p_ready[sel], 0);
      if (o_valid[sel] && ready_v[sel]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", cur_beat(), 0);
        end else begin
          chk("beat", cur_beat(), exp_q.pop_front());
        end
        beat_cnt++;
        flag_cnt += int'(o_flag[sel]);
        last_cnt += int'(o_last[sel]);
      end
      if (o_done[sel]) begin
        done_cnt++;
        chk("done_after_last", exp_q.size(), 0);
        chk("done_not_busy", o_busy[sel], 0);
      end
      stall_prev = o_valid[sel] && !ready_v[sel];
      prev_beat  = cur_beat();
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- frame driver ----------------
  task automatic run_frame(input bit c8, input bit st, input int gap_pct, input int hold_at,
                           input bit extra_start, input int abort_after, output int flags);
    int m, d0, accepted;
    bit acc;
    m = (sel == 1) ? 16 : 4;
    beat_cnt = 0; flag_cnt = 0; last_cnt = 0;
    d0 = done_cnt;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < m; j++)
        exp_q.push_back({ref_flag(i, j, m, m, c8, st), 4'(i), 4'(j), (i == m-1 && j == m-1)});
    @(posedge clk); #1;
    conn8_in = c8; strict_in = st; start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    accepted = 0;
    for (int p = 0; p < m*m; p++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        valid_v[sel] = 1'b0;
        @(posedge clk); #1;
      end
      pix_in = 8'(img[p/m][p%m]);
      valid_v[sel] = 1'b1;
      if (p == hold_at) hold_go = 1'b1;
      if (extra_start && p == 3) begin
        start_v[sel] = 1'b1; conn8_in = !c8; strict_in = !st;
      end
      acc = 1'b0;
      for (int t = 0; t < 400 && !acc; t++) begin
        @(negedge clk);
        acc = p_ready[sel];
        @(posedge clk); #1;
      end
      start_v[sel] = 1'b0;
      valid_v[sel] = 1'b0;
      if (!acc) begin
        chk("pixel_accept_timeout", 0, 1);
        flags = -1;
        return;
      end
      accepted++;
      if (abort_after > 0 && accepted == abort_after) begin
        flags = -1;
        return;
      end
    end
    for (int t = 0; t < 6000 && done_cnt == d0; t++) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", o_done[sel], 0);
    chk("frame_beats", beat_cnt, m*m);
    chk("frame_last_cnt", last_cnt, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("idle_after_frame", dbg[sel], IDLE);
    exp_q.delete();
    flags = flag_cnt;
  endtask

  task automatic chk_zero(input string nm, input int s);
    chk(nm, {p_ready[s], o_valid[s], o_flag[s], o_i[s], o_j[s], o_last[s], o_busy[s], o_done[s]}, 0);
    chk({nm, "_state"}, dbg[s], IDLE);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int fl, d0;
    repeat (3) @(posedge clk); #1;
    chk_zero("reset_outputs4", 0);
    chk_zero("reset_outputs16", 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Flat image: ties everywhere.
    sel = 0; rdy_pct = 100;
    fill_const(5);
    run_frame(1'b0, 1'b0, 0, -1, 1'b0, 0, fl); chk("flat_nonstrict_flags", fl, 16);
    run_frame(1'b0, 1'b1, 0, -1, 1'b0, 0, fl); chk("flat_strict_flags", fl, 0);

    // Two peaks on a zero floor.
    fill_const(0); img[1][1] = 5; img[2][2] = 7;
    run_frame(1'b0, 1'b1, 0, -1, 1'b0, 0, fl); chk("peaks_conn4_flags", fl, 2);
    run_frame(1'b1, 1'b1, 0, -1, 1'b0, 0, fl); chk("peaks_conn8_flags", fl, 1);

    // Bright corner: only its three neighbours lose.
    fill_const(0); img[0][0] = 255;
    run_frame(1'b1, 1'b0, 0, -1, 1'b0, 0, fl); chk("corner_flags", fl, 13);

    // Ten-cycle downstream hold in mid-frame.
    fill_img(3);
    run_frame(1'b1, 1'b0, 0, 8, 1'b0, 0, fl);

    // Randomized frames with input gaps, random out_ready and ignored starts.
    rdy_pct = 60;
    for (int f = 0; f < 20; f++) begin
      sel = f % 2;
      fill_img((f % 3 == 0) ? 255 : 3);
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 50, -1, 1'b1, 0, fl);
    end

    // Abort mid-frame with reset, then a clean frame.
    sel = 0; rdy_pct = 70;
    fill_img(3);
    run_frame(1'b0, 1'b0, 0, -1, 1'b0, 7, fl);
    reset_n = 1'b0;
    #1;
    chk_zero("abort_outputs", 0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (4) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("no_done_after_abort", done_cnt, d0);
    fill_img(255);
    run_frame(1'b1, 1'b1, 30, -1, 1'b0, 0, fl);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
